// File: rtl/axi3_cmd_master_128.sv
// axi3_cmd_master_128: turns one command into one AXI3 INCR burst on a 128-bit bus.
// Optional per-channel watchdog enabled by defining AXI3_MST_TIMEOUT_EN.
module axi3_cmd_master_128 #(
    parameter logic [3:0] ID_VAL      = 4'h0,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic         i_aclk,
    input  logic         i_areset,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic         i_cmd_wr,
    input  logic [31:0]  i_cmd_addr,
    input  logic [3:0]   i_cmd_len,
    input  logic [127:0] i_wd_data,
    input  logic [15:0]  i_wd_strb,
    input  logic         i_wd_valid,
    output logic         o_wd_ready,
    output logic [127:0] o_rd_data,
    output logic         o_rd_valid,
    output logic         o_rd_last,
    input  logic         i_rd_ready,
    output logic         o_done,
    output logic [1:0]   o_resp,
    output logic         o_err,
    output logic [3:0]   o_awid,
    output logic [31:0]  o_awaddr,
    output logic [3:0]   o_awlen,
    output logic [2:0]   o_awsize,
    output logic [1:0]   o_awburst,
    output logic [1:0]   o_awlock,
    output logic [3:0]   o_awcache,
    output logic [2:0]   o_awprot,
    output logic         o_awvalid,
    input  logic         i_awready,
    output logic [3:0]   o_wid,
    output logic [127:0] o_wdata,
    output logic [15:0]  o_wstrb,
    output logic         o_wlast,
    output logic         o_wvalid,
    input  logic         i_wready,
    input  logic [3:0]   i_bid,
    input  logic [1:0]   i_bresp,
    input  logic         i_bvalid,
    output logic         o_bready,
    output logic [3:0]   o_arid,
    output logic [31:0]  o_araddr,
    output logic [3:0]   o_arlen,
    output logic [2:0]   o_arsize,
    output logic [1:0]   o_arburst,
    output logic [1:0]   o_arlock,
    output logic [3:0]   o_arcache,
    output logic [2:0]   o_arprot,
    output logic         o_arvalid,
    input  logic         i_arready,
    input  logic [3:0]   i_rid,
    input  logic [127:0] i_rdata,
    input  logic [1:0]   i_rresp,
    input  logic         i_rlast,
    input  logic         i_rvalid,
    output logic         o_rready
);
    typedef enum logic [2:0] {IDLE, CHK, AW, W, B, AR, R, DONE} state_t;
    state_t       state_q, state_d;
    logic [31:4]  addr_q, addr_d;
    logic [3:0]   len_q, len_d, cnt_q, cnt_d;
    logic         wr_q, wr_d, err_q, err_d;
    logic [1:0]   resp_q, resp_d;
    logic         last_beat;
    assign last_beat = cnt_q == len_q;
    assign o_awid    = ID_VAL;
    assign o_awaddr  = {addr_q, 4'h0};
    assign o_awlen   = len_q;
    assign o_awsize  = 3'b100;
    assign o_awburst = 2'b01;
    assign o_awlock  = 2'b00;
    assign o_awcache = 4'h0;
    assign o_awprot  = 3'h0;
    assign o_arid    = ID_VAL;
    assign o_araddr  = {addr_q, 4'h0};
    assign o_arlen   = len_q;
    assign o_arsize  = 3'b100;
    assign o_arburst = 2'b01;
    assign o_arlock  = 2'b00;
    assign o_arcache = 4'h0;
    assign o_arprot  = 3'h0;
    assign o_wid     = ID_VAL;
    assign o_wdata   = i_wd_data;
    assign o_wstrb   = i_wd_strb;
    assign o_wlast   = (state_q == W) && last_beat;
    assign o_rd_data = (state_q == R) ? i_rdata : '0;
    assign o_rd_last = (state_q == R) && i_rlast;
    assign o_resp    = resp_q;
    assign o_err     = err_q;
`ifdef AXI3_MST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          busy, hs;
`endif
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        resp_d      = resp_q;
        o_cmd_ready = 1'b0;
        o_awvalid   = 1'b0;
        o_wvalid    = 1'b0;
        o_wd_ready  = 1'b0;
        o_bready    = 1'b0;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        o_rd_valid  = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr[31:4];
                    len_d   = i_cmd_len;
                    wr_d    = i_cmd_wr;
                    cnt_d   = 4'h0;
                    err_d   = 1'b0;
                    resp_d  = 2'b00;
                    state_d = CHK;
                end
            end
            CHK: begin
                // a burst whose last beat lands past the 4 KB page is refused outright
                if (9'(addr_q[11:4]) + 9'(len_q) > 9'd255) begin
                    err_d   = 1'b1;
                    resp_d  = 2'b10;
                    state_d = DONE;
                end else
                    state_d = wr_q ? AW : AR;
            end
            AW: begin
                o_awvalid = 1'b1;
                state_d   = i_awready ? W : AW;
            end
            W: begin
                o_wvalid   = i_wd_valid;
                o_wd_ready = i_wready;
                if (i_wd_valid && i_wready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_beat ? B : W;
                end
            end
            B: begin
                o_bready = 1'b1;
                if (i_bvalid) begin
                    resp_d  = i_bresp;
                    err_d   = err_q | (i_bid != ID_VAL);
                    state_d = DONE;
                end
            end
            AR: begin
                o_arvalid = 1'b1;
                state_d   = i_arready ? R : AR;
            end
            R: begin
                o_rready   = i_rd_ready;
                o_rd_valid = i_rvalid;
                if (i_rvalid && i_rd_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    resp_d  = (resp_q == 2'b00) ? i_rresp : resp_q;
                    err_d   = err_q | (i_rid != ID_VAL) | (i_rlast && !last_beat);
                    state_d = i_rlast ? DONE : R;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI3_MST_TIMEOUT_EN
        busy = state_q inside {AW, W, B, AR, R};
        hs   = (o_awvalid && i_awready) || (o_wvalid && i_wready) || (o_bready && i_bvalid) ||
               (o_arvalid && i_arready) || (o_rready && i_rvalid);
        if (busy && !hs && tmr_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
            resp_d  = 2'b11;
        end
        tmr_d = (!busy || hs || state_d != state_q) ? '0 : tmr_q + 1'b1;
`endif
    end
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            resp_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            resp_q  <= resp_d;
        end
    end
`ifdef AXI3_MST_TIMEOUT_EN
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset)
            tmr_q <= '0;
        else
            tmr_q <= tmr_d;
    end
`endif
endmodule

// File: tb/tb_axi3_cmd_master_128.sv
// tb_axi3_cmd_master_128: directed and randomized commands against a transaction-level model.
module tb_axi3_cmd_master_128;
    localparam logic [3:0] ID = 4'h0;
    logic         i_aclk = 0, i_areset = 1;
    logic         i_cmd_valid = 0, i_cmd_wr = 0;
    logic [31:0]  i_cmd_addr = 0;
    logic [3:0]   i_cmd_len = 0;
    logic [127:0] i_wd_data = 0;
    logic [15:0]  i_wd_strb = 0;
    logic         i_wd_valid = 0, i_rd_ready = 0;
    logic         i_awready = 0, i_wready = 0, i_bvalid = 0, i_arready = 0, i_rvalid = 0, i_rlast = 0;
    logic [3:0]   i_bid = 0, i_rid = 0;
    logic [1:0]   i_bresp = 0, i_rresp = 0;
    logic [127:0] i_rdata = 0;
    logic         o_cmd_ready, o_wd_ready, o_rd_valid, o_rd_last, o_done, o_err;
    logic [127:0] o_rd_data, o_wdata;
    logic [1:0]   o_resp, o_awburst, o_awlock, o_arburst, o_arlock;
    logic [3:0]   o_awid, o_awlen, o_awcache, o_wid, o_arid, o_arlen, o_arcache;
    logic [31:0]  o_awaddr, o_araddr;
    logic [2:0]   o_awsize, o_awprot, o_arsize, o_arprot;
    logic [15:0]  o_wstrb;
    logic         o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;
    int total = 0, bad = 0;
    bit k_fast = 0;
    int k_hold = 0, k_rr = -1, k_last = -1, k_rid_bad = -1, k_rst_beat = -1;

    axi3_cmd_master_128 #(.ID_VAL(ID)) dut (
        .i_aclk(i_aclk), .i_areset(i_areset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_wd_data(i_wd_data), .i_wd_strb(i_wd_strb), .i_wd_valid(i_wd_valid), .o_wd_ready(o_wd_ready),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last), .i_rd_ready(i_rd_ready),
        .o_done(o_done), .o_resp(o_resp), .o_err(o_err),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache), .o_awprot(o_awprot),
        .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arlock(o_arlock), .o_arcache(o_arcache), .o_arprot(o_arprot),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    always #5 i_aclk = ~i_aclk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic quiet_slave();
        i_wd_valid = 0; i_bvalid = 0; i_rvalid = 0; i_rlast = 0;
        i_awready = 0; i_arready = 0; i_wready = 0; i_rd_ready = 0;
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        logic [127:0] wd [16];
        logic [15:0]  ws [16];
        logic [127:0] rd [16];
        logic [1:0]   rr [16];
        logic [3:0]   rid [16];
        logic [1:0]   bresp, exp_resp;
        logic [3:0]   bid;
        logic         exp_err, xing;
        int           last_at, wi, rn, n, hold;
        bit           aw_seen, ar_seen, b_pend, done;
        for (int k = 0; k < 16; k++) begin
            wd[k]  = {$urandom, $urandom, $urandom, $urandom};
            ws[k]  = 16'($urandom);
            rd[k]  = {$urandom, $urandom, $urandom, $urandom};
            rr[k]  = (k_rr >= 0) ? 2'(k_rr) : (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
            rid[k] = (!k_fast && $urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : ID;
        end
        if (k_rid_bad >= 0) rid[k_rid_bad] = 4'h5;
        last_at = (k_last >= 0) ? k_last :
                  (!k_fast && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : int'(len);
        bresp = k_fast ? 2'b00 : 2'($urandom);
        bid   = (!k_fast && $urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : ID;
        // expected outcome from the transaction rules alone
        xing     = (int'(addr[11:4]) + int'(len)) > 255;
        exp_resp = 2'b00;
        exp_err  = 1'b0;
        if (xing) begin
            exp_err  = 1'b1;
            exp_resp = 2'b10;
        end else if (wr) begin
            exp_resp = bresp;
            exp_err  = bid != ID;
        end else begin
            for (int k = 0; k <= last_at; k++) begin
                if (exp_resp == 2'b00) exp_resp = rr[k];
                if (rid[k] != ID) exp_err = 1'b1;
            end
            if (last_at != int'(len)) exp_err = 1'b1;
        end
        @(negedge i_aclk);
        i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_len = len;
        #1 check("cmd_ready", o_cmd_ready, 1);
        @(posedge i_aclk);
        wi = 0; rn = 0; n = 0; hold = k_hold;
        aw_seen = 0; ar_seen = 0; b_pend = 0; done = 0;
        while (!done && n < 3000) begin
            @(negedge i_aclk);
            i_cmd_valid = o_cmd_ready ? 1'b0 : 1'($urandom);
            i_cmd_wr    = 1'($urandom);
            i_cmd_addr  = $urandom;
            i_cmd_len   = 4'($urandom);
            i_awready   = k_fast | 1'($urandom);
            i_arready   = k_fast | 1'($urandom);
            i_wready    = k_fast | 1'($urandom);
            i_wd_valid  = wr && wi <= int'(len) && (k_fast || 1'($urandom));
            i_wd_data   = wd[wi & 15];
            i_wd_strb   = ws[wi & 15];
            i_bvalid    = b_pend && (k_fast || 1'($urandom));
            i_bresp     = bresp;
            i_bid       = bid;
            i_rvalid    = ar_seen && rn <= last_at && (k_fast || 1'($urandom));
            i_rdata     = rd[rn & 15];
            i_rresp     = rr[rn & 15];
            i_rid       = rid[rn & 15];
            i_rlast     = rn == last_at;
            i_rd_ready  = (ar_seen && hold > 0) ? 1'b0 : (k_fast | 1'($urandom));
            #1;
            if (o_awvalid || o_arvalid) check("addr_ch_xing", xing, 0);
            if (o_awvalid && i_awready) begin
                check("aw", {wr, o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awlock, o_awcache, o_awprot},
                      {1'b1, ID, addr[31:4], 4'h0, len, 3'b100, 2'b01, 2'b00, 4'h0, 3'h0});
                aw_seen = 1;
            end
            if (o_arvalid && i_arready) begin
                check("ar", {wr, o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arlock, o_arcache, o_arprot},
                      {1'b0, ID, addr[31:4], 4'h0, len, 3'b100, 2'b01, 2'b00, 4'h0, 3'h0});
                ar_seen = 1;
            end
            if ((i_wd_valid && o_wd_ready) || (o_wvalid && i_wready)) begin
                check("w_pass", i_wd_valid && o_wd_ready, o_wvalid && i_wready);
                check("w_beat", {aw_seen, o_wid, o_wlast, o_wstrb, o_wdata},
                      {1'b1, ID, wi == int'(len), ws[wi & 15], wd[wi & 15]});
                wi++;
                if (wi == int'(len) + 1) b_pend = 1;
                if (wi == k_rst_beat) begin
                    @(posedge i_aclk);
                    #2 i_areset = 1;
                    #1 check("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_rd_valid,
                                            o_wd_ready, o_done, o_err, o_resp}, 0);
                    quiet_slave();
                    i_cmd_valid = 0;
                    @(negedge i_aclk);
                    i_areset = 0;
                    #1 check("rst_cmd_ready", o_cmd_ready, 1);
                    return;
                end
            end
            if (o_bready && i_bvalid) b_pend = 0;
            if (ar_seen && hold > 0) begin
                check("rready_hold", o_rready, 0);
                hold--;
            end
            if (i_rvalid && o_rready) begin
                check("r_beat", {o_rd_valid, o_rd_last, o_rd_data}, {1'b1, rn == last_at, rd[rn & 15]});
                rn++;
            end
            if (o_done) begin
                if (k_fast && wr && !xing) check("w_lat", n, 4 + int'(len));
                if (xing) check("xing_lat", n, 1);
                check("done_resp", {o_err, o_resp}, {exp_err, exp_resp});
                if (!xing) check("beats", wr ? wi : rn, wr ? int'(len) + 1 : last_at + 1);
                done = 1;
            end
            @(posedge i_aclk);
            n++;
        end
        if (!done) check("done_wait", 0, 1);
        @(negedge i_aclk);
        i_cmd_valid = 0;
        quiet_slave();
        #1 check("after_done", {o_done, o_cmd_ready, o_err, o_resp}, {1'b0, 1'b1, exp_err, exp_resp});
    endtask

    task automatic knobs_default();
        k_fast = 0; k_hold = 0; k_rr = -1; k_last = -1; k_rid_bad = -1; k_rst_beat = -1;
    endtask

    initial begin
        logic [31:0] a;
        #1 check("reset_state", {o_cmd_ready, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_wd_ready,
                                 o_rd_valid, o_rd_last, o_done, o_err, o_resp}, {1'b1, 12'h0});
        repeat (3) @(posedge i_aclk);
        @(negedge i_aclk);
        i_areset = 0;
        k_fast = 1;
        run_cmd(1'b1, 32'h1000_0008, 4'd3);
        k_hold = 3; k_rr = 2;
        run_cmd(1'b0, 32'h2000_0040, 4'd0);
        knobs_default(); k_fast = 1;
        run_cmd(1'b1, 32'h0000_0FF0, 4'd1);
        k_last = 2; k_rid_bad = 2;
        run_cmd(1'b0, 32'h3000_0100, 4'd3);
        knobs_default(); k_fast = 1; k_rst_beat = 2;
        run_cmd(1'b1, 32'h4000_0000, 4'd3);
        knobs_default(); k_fast = 1;
        run_cmd(1'b1, 32'h4000_0200, 4'd2);
        run_cmd(1'b0, 32'h0000_0F00, 4'd15);
        knobs_default();
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[11:4] = 8'($urandom_range(240, 255));
            run_cmd(1'($urandom), a, 4'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
